// File: rtl/pipe_em_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, write-enable gating
// and a saturating stall counter. Optional 2-entry skid storage: PIPE_EM_SKID_EN.
module pipe_em_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mux_dir_mem_in,
  input  logic                  mux_dato_in,
  input  logic                  write_mem_in,
  input  logic                  write_reg_in,
  input  logic [DATA_W-1:0]     dir_mem_carga_in,
  input  logic [DATA_W-1:0]     dato_result_in,
  input  logic [DATA_W-1:0]     dir_mem_reg_b_in,
  input  logic [REG_ADDR_W-1:0] dir_write_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  mux_dir_mem_out,
  output logic                  mux_dato_out,
  output logic                  write_mem_out,
  output logic                  write_reg_out,
  output logic [DATA_W-1:0]     dir_mem_carga_out,
  output logic [DATA_W-1:0]     dato_result_out,
  output logic [DATA_W-1:0]     dir_mem_reg_b_out,
  output logic [REG_ADDR_W-1:0] dir_write_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  mux_dir_mem;
    logic                  mux_dato;
    logic                  write_mem;
    logic                  write_reg;
    logic [DATA_W-1:0]     carga;
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     reg_b;
    logic [REG_ADDR_W-1:0] dir_write;
  } pkt_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pkt_t in_pkt;
  pkt_t main_p0;
  logic vld_p0;
  logic accept;
  logic retire;

  assign in_pkt = '{mux_dir_mem: mux_dir_mem_in, mux_dato: mux_dato_in,
                    write_mem: write_mem_in, write_reg: write_reg_in,
                    carga: dir_mem_carga_in, result: dato_result_in,
                    reg_b: dir_mem_reg_b_in, dir_write: dir_write_in};

  assign accept = in_valid & in_ready;
  assign retire = vld_p0 & out_ready;

`ifdef PIPE_EM_SKID_EN
  pkt_t skid_p0;
  logic skid_vld_p0;
  logic rdy_q;

  assign in_ready = rdy_q;

  // EX -> main/skid capture; skid only fills while main is held by MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      skid_vld_p0 <= 1'b0;
      main_p0     <= '0;
      skid_p0     <= '0;
      rdy_q       <= 1'b1;
    end else if (flush) begin
      vld_p0      <= 1'b0;
      skid_vld_p0 <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      if (retire) begin
        if (skid_vld_p0) begin
          main_p0     <= skid_p0;
          skid_vld_p0 <= 1'b0;
        end else if (accept) begin
          main_p0 <= in_pkt;
        end else begin
          vld_p0 <= 1'b0;
        end
      end else if (accept) begin
        if (vld_p0) begin
          skid_p0     <= in_pkt;
          skid_vld_p0 <= 1'b1;
        end else begin
          main_p0 <= in_pkt;
          vld_p0  <= 1'b1;
        end
      end
      // in_ready tracks the next-cycle emptiness of the skid slot
      rdy_q <= skid_vld_p0 ? retire : ~(accept & vld_p0 & ~retire);
    end
  end
`else
  assign in_ready = ~vld_p0 | out_ready;

  // EX -> main capture; accept can only happen when main is empty or retiring
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      main_p0 <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      main_p0 <= in_pkt;
      vld_p0  <= 1'b1;
    end else if (retire) begin
      vld_p0 <= 1'b0;
    end
  end
`endif

  // Stall counter keeps counting through flushes; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (vld_p0 & ~out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign out_valid         = vld_p0;
  assign mux_dir_mem_out   = main_p0.mux_dir_mem;
  assign mux_dato_out      = main_p0.mux_dato;
  assign write_mem_out     = main_p0.write_mem & vld_p0;
  assign write_reg_out     = main_p0.write_reg & vld_p0;
  assign dir_mem_carga_out = main_p0.carga;
  assign dato_result_out   = main_p0.result;
  assign dir_mem_reg_b_out = main_p0.reg_b;
  assign dir_write_out     = main_p0.dir_write;

endmodule

// File: tb/tb_pipe_em_stage.sv
// Self-checking bench for pipe_em_stage: directed steps plus random traffic
// checked against a FIFO-capacity reference model.
module tb_pipe_em_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_EM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic          mdm;
    logic          md;
    logic          wm;
    logic          wr;
    logic [DW-1:0] carga;
    logic [DW-1:0] res;
    logic [DW-1:0] regb;
    logic [RW-1:0] dw;
  } pkt_t;
  localparam int PW = $bits(pkt_t);

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic mdm_i, md_i, wm_i, wr_i, mdm_o, md_o, wm_o, wr_o;
  logic [DW-1:0] carga_i, res_i, regb_i, carga_o, res_o, regb_o;
  logic [RW-1:0] dw_i, dw_o;
  logic [CW-1:0] stall_cnt;

  pipe_em_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mux_dir_mem_in(mdm_i), .mux_dato_in(md_i), .write_mem_in(wm_i), .write_reg_in(wr_i),
    .dir_mem_carga_in(carga_i), .dato_result_in(res_i), .dir_mem_reg_b_in(regb_i),
    .dir_write_in(dw_i), .out_valid(out_valid), .out_ready(out_ready),
    .mux_dir_mem_out(mdm_o), .mux_dato_out(md_o), .write_mem_out(wm_o),
    .write_reg_out(wr_o), .dir_mem_carga_out(carga_o), .dato_result_out(res_o),
    .dir_mem_reg_b_out(regb_o), .dir_write_out(dw_o), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pkt_t q[$];
  int   cnt;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rnd_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic pkt_t mk_pkt(input logic [DW-1:0] res, input logic wm, input logic wr);
    pkt_t p;
    p = rnd_pkt();
    p.res = res;
    p.wm  = wm;
    p.wr  = wr;
    return p;
  endfunction

  function automatic bit model_rdy(input bit ordy);
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic chk_outputs();
    bit   v;
    pkt_t e;
    v = q.size() > 0;
    e = v ? q[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("write_mem_out", 64'(wm_o), 64'(v & e.wm));
    chk("write_reg_out", 64'(wr_o), 64'(v & e.wr));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt));
    if (v) begin
      chk("payload_ctl", 64'({mdm_o, md_o}), 64'({e.mdm, e.md}));
      chk("dato_result_out", 64'(res_o), 64'(e.res));
      chk("dir_mem_carga_out", 64'(carga_o), 64'(e.carga));
      chk("dir_mem_reg_b_out", 64'(regb_o), 64'(e.regb));
      chk("dir_write_out", 64'(dw_o), 64'(e.dw));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_ctl"}, 64'({mdm_o, md_o, wm_o, wr_o}), 64'(0));
    chk({tag, "_data"}, 64'(carga_o | res_o | regb_o), 64'(0));
    chk({tag, "_dw"}, 64'(dw_o), 64'(0));
  endtask

  // One clock: drive at edge+1, check in_ready, advance model, check outputs at edge+1
  task automatic cycle(input bit r, input bit f, input bit iv, input bit ordy, input pkt_t p);
    bit rdy;
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    {mdm_i, md_i, wm_i, wr_i} = {p.mdm, p.md, p.wm, p.wr};
    carga_i = p.carga; res_i = p.res; regb_i = p.regb; dw_i = p.dw;
    #1;
    rdy = model_rdy(ordy);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (r) begin
      q.delete();
      cnt = 0;
    end else begin
      if (q.size() > 0 && !ordy && cnt < CMAX) cnt++;
      if (f) q.delete();
      else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && rdy) q.push_back(p);
      end
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  initial begin
    checks = 0; errors = 0; cnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {mdm_i, md_i, wm_i, wr_i} = '0;
    carga_i = '0; res_i = '0; regb_i = '0; dw_i = '0;
    @(posedge clk);
    #1;

    // reset then stream 1,2,3
    cycle(1, 0, 0, 1, rnd_pkt());
    cycle(1, 0, 0, 1, rnd_pkt());
    chk_zero("reset");
    rst = 1'b0; #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    cycle(0, 0, 1, 1, mk_pkt(32'd1, 1'b0, 1'b1));
    chk("stream_first", 64'(res_o), 64'(1));
    cycle(0, 0, 1, 1, mk_pkt(32'd2, 1'b1, 1'b0));
    cycle(0, 0, 1, 1, mk_pkt(32'd3, 1'b0, 1'b0));
    chk("stream_third", 64'(res_o), 64'(3));
    chk("stream_cnt", 64'(stall_cnt), 64'(0));
    cycle(0, 0, 0, 1, rnd_pkt());

    // stall hold with 0xA5A5A5A5
    cycle(1, 0, 0, 1, rnd_pkt());
    cycle(0, 0, 1, 1, mk_pkt(32'hA5A5A5A5, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, rnd_pkt());
    chk("stall_hold_data", 64'(res_o), 64'(32'hA5A5A5A5));
    chk("stall_hold_wm", 64'(wm_o), 64'(1));
    chk("stall_cnt_4", 64'(stall_cnt), 64'(4));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, rnd_pkt());

    // skid order: X then Y
    cycle(1, 0, 0, 1, rnd_pkt());
    cycle(0, 0, 1, 1, mk_pkt(32'h10, 1'b0, 1'b0));
    cycle(0, 0, 1, 0, mk_pkt(32'h20, 1'b0, 1'b0));
    chk("skid_x_held", 64'(res_o), 64'(32'h10));
    cycle(0, 0, 1, 1, mk_pkt(32'h20, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, rnd_pkt());

    // flush with a writing instruction incoming while main is valid
    cycle(0, 0, 1, 1, mk_pkt(32'h33, 1'b1, 1'b1));
    cycle(0, 1, 1, 0, mk_pkt(32'h44, 1'b1, 1'b1));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_we", 64'({wr_o, wm_o}), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    cycle(0, 0, 0, 1, rnd_pkt());

    // counter saturation, then rst clears it
    cycle(1, 0, 0, 1, rnd_pkt());
    cycle(0, 0, 1, 1, rnd_pkt());
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, rnd_pkt());
    chk("sat_cnt", 64'(stall_cnt), 64'(15));
    cycle(0, 0, 0, 0, rnd_pkt());
    cycle(1, 0, 0, 0, rnd_pkt());
    chk("sat_cnt_rst", 64'(stall_cnt), 64'(0));

    // reset mid-stall
    cycle(0, 0, 1, 1, mk_pkt(32'h55, 1'b1, 1'b1));
    cycle(0, 0, 1, 0, rnd_pkt());
    cycle(0, 0, 0, 0, rnd_pkt());
    cycle(1, 0, 1, 0, rnd_pkt());
    chk_zero("rst_mid_stall");
    chk("rst_mid_stall_cnt", 64'(stall_cnt), 64'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rnd_pkt());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_em_stage.md
# pipe_em_stage

Parametrised EX/MEM pipeline stage register with valid/ready handshake, synchronous flush, write-enable squashing and a stall-cycle counter. It sits between the execute stage (ALU result, store data, destination register) and the memory stage of the 32-bit processor. It replaces a free-running capture register with one that supports back-pressure from memory and pipeline kills from branch resolution.

## Interface
- DATA_W, 32, width of the address/result/store-data fields
- REG_ADDR_W, 5, width of the destination register index
- CNT_W, 16, width of the stall counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all held and incoming instructions
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept this cycle
- mux_dir_mem_in, mux_dato_in, write_mem_in, write_reg_in  in  1 each  control bits from EX
- dir_mem_carga_in, dato_result_in, dir_mem_reg_b_in  in  DATA_W each  load address, ALU result, store data
- dir_write_in  in  REG_ADDR_W  destination register
- out_valid  out  1  MEM-side instruction valid
- out_ready  in  1  MEM consumes this cycle
- mux_dir_mem_out, mux_dato_out, write_mem_out, write_reg_out  out  1 each  registered control; write_* gated by out_valid
- dir_mem_carga_out, dato_result_out, dir_mem_reg_b_out  out  DATA_W each
- dir_write_out  out  REG_ADDR_W
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Accept: in_valid & in_ready at a clk edge; payload captured into main register (or skid register, see Configuration).
- Transfer: out_valid & out_ready at a clk edge retires the main entry.
- Simultaneous accept and retire: new payload replaces main; out_valid stays 1.
- Stall: out_valid=1, out_ready=0 holds main payload bit-stable.
- write_mem_out = main.write_mem & out_valid; write_reg_out likewise. An invalid slot never produces a write enable.
- Flush: at the edge, all valid bits cleared, the same-cycle input is discarded regardless of in_ready; payload registers may keep stale data but write_* outputs are 0. Flush has priority over accept, transfer and stall.
- stall_cnt: +1 on every edge where out_valid & ~out_ready; saturates at 2^CNT_W-1; not cleared by flush, only by rst.
- Reset (rst=1 at an edge): all valid bits, all payload outputs and stall_cnt to 0; in_ready reads 1 in the first cycle after rst deasserts. Reset mid-stall drops the held instruction.

## Timing
- Latency: 1 cycle in->out; throughput 1 instruction/cycle with out_ready held 1.
- Without the macro, in_ready = ~out_valid | out_ready (combinational path from out_ready).
- With the macro, in_ready is a register output; no combinational path from any input to in_ready.
- Payload and control outputs are direct register outputs except write_*_out (one AND gate).

## Configuration
- PIPE_EM_SKID_EN defined: 2-entry storage (main + skid). in_ready = ~skid_valid, registered. If main is stalled and an instruction is accepted, it lands in skid; on the next transfer skid moves to main (same edge may accept a new input into skid only if skid empties). Order is strictly preserved. Flush clears both entries.
- Not defined: single main entry; in_ready combinational as in Timing; no skid register.

## Test plan
- Reset then stream: rst 2 cycles, in_valid=1, out_ready=1, dato_result_in=1,2,3 -> dato_result_out=1,2,3 on successive cycles, out_valid=1 one cycle after first accept, stall_cnt=0.
- Stall hold: out_ready=0 for 4 cycles with main holding dato_result=0xA5A5A5A5, write_mem=1 -> outputs bit-stable, stall_cnt=4; without macro in_ready=0, with macro one extra input accepted then in_ready=0.
- Skid order (macro on): accept X=0x10, stall, accept Y=0x20, release out_ready -> out 0x10 then 0x20, no loss, no duplicate.
- Flush with write_reg_in=1 and in_valid=1 while main valid -> next cycle out_valid=0, write_reg_out=0, write_mem_out=0; in_ready=1.
- Counter saturation with CNT_W=4: hold stall 20 cycles -> stall_cnt=15 and stays; rst -> 0.
- Reset mid-stall: valid entry stalled, assert rst -> out_valid=0, all outputs 0 next cycle.
